aes_result_uart: RTL and testbench

Demonstration-side consumer of the encrypted block output of the USB/AES top level. It captures each 128-bit `data_out` word qualified by `complete` and serialises it over a UART TX line for bench or board logging. Each block is sent as one 17-byte frame: header byte 0xA5, then 16 data bytes, most significant byte first. A one-deep pending buffer absorbs a block that arrives while a frame is in flight; further arrivals are dropped and flagged.

---
 rtl/aes_result_uart.sv | 166 ++++++++++++++++
 tb/tb_aes_result_uart.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_uart.sv
// Serialises each captured 128-bit encrypted block as a 17-byte UART frame
// (header byte, then data bytes MSB first), with a one-deep pending buffer.
module aes_result_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         complete,
  input  logic [127:0] data_in,
  output logic         tx,
  output logic         busy,
  output logic         overrun,
  output logic [7:0]   blocks_sent
);

  localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LAST_BYTE = 5'd16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q;
  logic [CW-1:0]  baud_q;
  logic [2:0]     bit_idx_q;
  logic [4:0]     byte_idx_q;
  logic           complete_q;
  logic [127:0]   active_q;
  logic [127:0]   pending_q;
  logic           active_valid_q;
  logic           pending_valid_q;
  logic           tx_q;
  logic           overrun_q;
  logic [7:0]     blocks_sent_q;

  logic           arrival;
  logic           baud_last;
  logic           frame_end;
  logic [3:0]     byte_rev;
  logic [127:0]   shifted;
  logic [7:0]     cur_byte;

  // Handshake: a block is offered by a 0->1 edge on complete with data_in valid
  // in that same cycle; there is no back-pressure, so excess arrivals are dropped.
  assign arrival   = complete & ~complete_q;
  assign baud_last = (baud_q == BAUD_MAX);
  assign frame_end = (state_q == STOP) && baud_last && (byte_idx_q == LAST_BYTE);

  // Byte k (1..16) sits (16-k) bytes above the LSB of the active block.
  assign byte_rev = 4'(LAST_BYTE - byte_idx_q);
  assign shifted  = active_q >> {byte_rev, 3'b000};
  assign cur_byte = (byte_idx_q == 5'd0) ? HEADER : shifted[7:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      baud_q          <= '0;
      bit_idx_q       <= '0;
      byte_idx_q      <= '0;
      complete_q      <= 1'b0;
      active_q        <= '0;
      pending_q       <= '0;
      active_valid_q  <= 1'b0;
      pending_valid_q <= 1'b0;
      tx_q            <= 1'b1;
      overrun_q       <= 1'b0;
      blocks_sent_q   <= '0;
    end else begin
      complete_q <= complete;

      case (state_q)
        IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (arrival || pending_valid_q) begin
            state_q    <= START;
            byte_idx_q <= '0;
            tx_q       <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_q + 5'd1;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              // Next frame starts straight out of the stop bit when a block is ready.
              blocks_sent_q <= blocks_sent_q + 8'd1;
              byte_idx_q    <= '0;
              if (pending_valid_q || arrival) begin
                tx_q    <= 1'b0;
                state_q <= START;
              end else begin
                tx_q    <= 1'b1;
                state_q <= IDLE;
              end
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (!active_valid_q) begin
        if (arrival) begin
          active_q       <= data_in;
          active_valid_q <= 1'b1;
        end else if (pending_valid_q) begin
          active_q        <= pending_q;
          active_valid_q  <= 1'b1;
          pending_valid_q <= 1'b0;
        end
      end else if (frame_end) begin
        if (pending_valid_q) begin
          active_q        <= pending_q;
          pending_valid_q <= arrival;
          if (arrival) pending_q <= data_in;
        end else if (arrival) begin
          active_q <= data_in;
        end else begin
          active_valid_q <= 1'b0;
        end
      end else if (arrival) begin
        if (!pending_valid_q) begin
          pending_q       <= data_in;
          pending_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign tx          = tx_q;
  assign busy        = (state_q != IDLE) | pending_valid_q;
  assign overrun     = overrun_q;
  assign blocks_sent = blocks_sent_q;

endmodule

// File: tb/tb_aes_result_uart.sv
// Directed bench for aes_result_uart: a UART decoder on tx feeds a byte
// scoreboard filled whenever a block that should be sent is offered.
module tb_aes_result_uart;

  localparam int unsigned CPB      = 4;
  localparam logic [7:0]  HDR      = 8'hA5;
  localparam int unsigned FRAME_CY = 170 * CPB;

  logic         clk;
  logic         n_rst;
  logic         complete;
  logic [127:0] data_in;
  logic         tx;
  logic         busy;
  logic         overrun;
  logic [7:0]   blocks_sent;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0]  exp_q[$];
  int unsigned fs_q[$];
  int unsigned pcyc = 0;
  int unsigned ncyc = 0;
  int unsigned cap_cyc;
  int unsigned cap_a;
  int unsigned flen;
  int          frame_cnt = 0;
  int          frames_before;

  bit          mon_act = 0;
  int          mon_cnt;
  logic [9:0]  mon_bits;
  bit          mon_wok;
  int          frame_byte = 0;
  int unsigned fstart;
  int unsigned bstart_prev;
  logic [7:0]  exp_byte;

  aes_result_uart #(.CLKS_PER_BIT(CPB), .HEADER(HDR)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .complete    (complete),
    .data_in     (data_in),
    .tx          (tx),
    .busy        (busy),
    .overrun     (overrun),
    .blocks_sent (blocks_sent)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) pcyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_block(input logic [127:0] d);
    exp_q.push_back(HDR);
    for (int k = 15; k >= 0; k--) exp_q.push_back(d[k*8 +: 8]);
  endtask

  // Called just after a posedge; the block is captured at the next posedge.
  task automatic pulse(input logic [127:0] d, input bit sent);
    if (sent) push_block(d);
    complete = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
    cap_cyc  = pcyc;
    complete = 1'b0;
    data_in  = rand128();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // UART decoder / scoreboard consumer
  always @(negedge clk) begin
    ncyc++;
    if (!n_rst) begin
      mon_act    = 0;
      frame_byte = 0;
    end else begin
      if (!mon_act && tx === 1'b0) begin
        mon_act = 1;
        mon_cnt = 0;
        mon_wok = 1;
        if (frame_byte == 0) begin
          fstart = ncyc;
          fs_q.push_back(ncyc);
        end else begin
          check("byte_gap", ncyc - bstart_prev, 10 * CPB);
        end
        bstart_prev = ncyc;
      end
      if (mon_act) begin
        if (mon_cnt % CPB == 0) mon_bits[mon_cnt / CPB] = tx;
        else if (tx !== mon_bits[mon_cnt / CPB]) mon_wok = 0;
        mon_cnt++;
        if (mon_cnt == 10 * CPB) begin
          mon_act = 0;
          check("start_bit", {31'd0, mon_bits[0]}, 32'd0);
          check("stop_bit", {31'd0, mon_bits[9]}, 32'd1);
          check("bit_width", {31'd0, mon_wok}, 32'd1);
          check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            exp_byte = exp_q.pop_front();
            check("byte_data", {24'd0, mon_bits[8:1]}, {24'd0, exp_byte});
          end
          frame_byte++;
          if (frame_byte == 17) begin
            frame_byte = 0;
            frame_cnt++;
            flen = ncyc - fstart + 1;
          end
        end
      end
    end
  end

  initial begin
    n_rst    = 1'b0;
    complete = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_blocks", {24'd0, blocks_sent}, 32'd0);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single block, one-cycle pulse
    fs_q.delete();
    pulse(128'h00112233445566778899AABBCCDDEEFF, 1'b1);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_tx", {31'd0, tx}, 32'd0);
    wait_idle(3000);
    check("single_blocks", {24'd0, blocks_sent}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd0);
    check("single_frame_len", flen, FRAME_CY);
    check("single_frames", fs_q.size(), 32'd1);

    // complete held high counts once
    frames_before = frame_cnt;
    data_in  = rand128();
    push_block(data_in);
    complete = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    complete = 1'b0;
    wait_idle(3000);
    check("held_frames", frame_cnt - frames_before, 32'd1);
    check("held_blocks", {24'd0, blocks_sent}, 32'd2);
    check("held_overrun", {31'd0, overrun}, 32'd0);

    // Two pulses 10 cycles apart: back-to-back frames
    fs_q.delete();
    pulse(rand128(), 1'b1);
    repeat (9) @(posedge clk);
    #1;
    pulse(rand128(), 1'b1);
    wait_idle(4000);
    check("pair_blocks", {24'd0, blocks_sent}, 32'd4);
    check("pair_overrun", {31'd0, overrun}, 32'd0);
    check("pair_frames", fs_q.size(), 32'd2);
    check("pair_spacing", fs_q[1] - fs_q[0], FRAME_CY);

    // Arrival in the exact cycle frame A ends while B is pending
    fs_q.delete();
    pulse(rand128(), 1'b1);
    cap_a = cap_cyc;
    repeat (9) @(posedge clk);
    #1;
    pulse(rand128(), 1'b1);
    while (pcyc < cap_a + FRAME_CY - 1) begin
      @(posedge clk);
      #1;
    end
    pulse(rand128(), 1'b1);
    check("edge_cap_cycle", cap_cyc - cap_a, FRAME_CY);
    check("edge_overrun_now", {31'd0, overrun}, 32'd0);
    wait_idle(6000);
    check("edge_blocks", {24'd0, blocks_sent}, 32'd7);
    check("edge_overrun", {31'd0, overrun}, 32'd0);
    check("edge_frames", fs_q.size(), 32'd3);
    check("edge_spacing_ab", fs_q[1] - fs_q[0], FRAME_CY);
    check("edge_spacing_bc", fs_q[2] - fs_q[1], FRAME_CY);

    // Three pulses during frame A: C is dropped
    pulse(rand128(), 1'b1);
    repeat (9) @(posedge clk);
    #1;
    pulse(rand128(), 1'b1);
    check("ovr_before_c", {31'd0, overrun}, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    pulse(rand128(), 1'b0);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    wait_idle(4000);
    check("ovr_blocks", {24'd0, blocks_sent}, 32'd9);
    repeat (20) @(posedge clk);
    #1;
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset 300 cycles into a frame
    pulse(rand128(), 1'b1);
    while (pcyc < cap_cyc + 300) begin
      @(posedge clk);
      #1;
    end
    n_rst = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_blocks", {24'd0, blocks_sent}, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    exp_q.delete();
    fs_q.delete();
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    pulse(rand128(), 1'b1);
    wait_idle(3000);
    check("post_rst_blocks", {24'd0, blocks_sent}, 32'd1);
    check("post_rst_frame_len", flen, FRAME_CY);
    check("post_rst_frames", fs_q.size(), 32'd1);
    check("post_rst_overrun", {31'd0, overrun}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
